// File: rtl/dct_pkg.sv
// Shared definitions for the DCT-IV input path.
// Used by the frame buffer, the DCT core and their benches.
//   DCT_N        samples per frame
//   DCT_DW       sample width
//   IDX_W        width of a sample index within one frame
//   bank_state_t per-bank life cycle of the ping-pong buffer
package dct_pkg;
  localparam int DCT_N  = 256;
  localparam int DCT_DW = 32;
  localparam int IDX_W  = $clog2(DCT_N);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_t;

  function automatic logic bank_writable(input bank_state_t s);
    return (s == BANK_EMPTY) || (s == BANK_FILLING);
  endfunction

  function automatic logic bank_readable(input bank_state_t s);
    return (s == BANK_FULL) || (s == BANK_DRAINING);
  endfunction
endpackage

// File: rtl/dct_frame_buffer_if.sv
// Valid/ready sample stream with an end-of-frame marker.
//   valid  producer has a sample
//   ready  consumer accepts it (transfer on valid && ready at rising clk)
//   data   sample, DW bits
//   last   end-of-frame marker
// master drives valid/data/last, slave drives ready.
interface dct_frame_buffer_if #(parameter int DW = dct_pkg::DCT_DW);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic          last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/dct_frame_buffer_ram.sv
// One bank of the ping-pong buffer: N x DW simple dual-port RAM.
//   clk      clock
//   we_i     write enable, waddr_i / wdata_i
//   re_i     read enable, raddr_i
//   rdata_o  read data, one cycle after re_i; holds its value while re_i is low
module dct_bank_ram #(
  parameter int DW = 32,
  parameter int N  = 256,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [N];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/dct_frame_buffer.sv
// Ping-pong input frame buffer in front of the DCT-IV core.
// Frames of N samples are written into one bank while the other bank is
// replayed in index order, so a sustained rate of one sample per cycle holds.
//   clk, rst_n  clock, asynchronous active-low reset
//   s_if        input sample stream (slave)
//   m_if        output sample stream to the DCT core (master), last on N-1
//   frame_err   one-cycle pulse when the producer's last disagrees with the count
//   frame_cnt   number of fully drained frames (wraps)
module dct_frame_buffer
  import dct_pkg::*;
#(
  parameter int DW   = DCT_DW,
  parameter int N    = DCT_N,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  dct_frame_buffer_if.slave  s_if,
  dct_frame_buffer_if.master m_if,
  output logic              frame_err,
  output logic [CNTW-1:0]   frame_cnt
);
  localparam int             IW       = $clog2(N);
  localparam logic [IW-1:0]  IDX_LAST = IW'(N - 1);

  bank_state_t     state_q [2];
  bank_state_t     state_d [2];
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic            iss_bank_q, iss_bank_d;
  logic [IW-1:0]   wr_idx_q, wr_idx_d;
  logic [IW-1:0]   iss_idx_q, iss_idx_d;
  logic            vld_p1_q, vld_p1_d;
  logic            bank_p1_q, bank_p1_d;
  logic            last_p1_q, last_p1_d;
  logic            m_valid_q, m_valid_d;
  logic [DW-1:0]   m_data_q, m_data_d;
  logic            m_last_q, m_last_d;
  logic            err_q, err_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic            s_fire, m_fire, adv_out, ren;
  logic [DW-1:0]   rdata [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dct_bank_ram #(.DW(DW), .N(N)) u_ram (
      .clk     (clk),
      .we_i    (s_fire && (wr_bank_q == 1'(b))),
      .waddr_i (wr_idx_q),
      .wdata_i (s_if.data),
      .re_i    (ren && (iss_bank_q == 1'(b))),
      .raddr_i (iss_idx_q),
      .rdata_o (rdata[b])
    );
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q[0] <= BANK_EMPTY;
      state_q[1] <= BANK_EMPTY;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      iss_bank_q <= 1'b0;
      wr_idx_q   <= '0;
      iss_idx_q  <= '0;
      vld_p1_q   <= 1'b0;
      bank_p1_q  <= 1'b0;
      last_p1_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      iss_bank_q <= iss_bank_d;
      wr_idx_q   <= wr_idx_d;
      iss_idx_q  <= iss_idx_d;
      vld_p1_q   <= vld_p1_d;
      bank_p1_q  <= bank_p1_d;
      last_p1_q  <= last_p1_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Output decode: handshakes and read issue, from registered state only
  always_comb begin
    s_if.ready = bank_writable(state_q[wr_bank_q]);
    s_fire     = s_if.valid && s_if.ready;
    m_fire     = m_valid_q && m_if.ready;
    adv_out    = !m_valid_q || m_if.ready;
    // The RAM output register is a holding stage of its own, so a new read
    // may issue whenever that stage is empty or moves into the output register.
    // The issue pointer runs ahead of rd_bank_q so the next full bank starts
    // reading before the current one has handed over its last sample.
    ren        = bank_readable(state_q[iss_bank_q]) && (!vld_p1_q || adv_out);
  end

  // Next state
  always_comb begin
    state_d    = state_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    iss_bank_d = iss_bank_q;
    wr_idx_d   = wr_idx_q;
    iss_idx_d  = iss_idx_q;
    vld_p1_d   = vld_p1_q;
    bank_p1_d  = bank_p1_q;
    last_p1_d  = last_p1_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    cnt_d      = cnt_q;
    err_d      = s_fire && (s_if.last != (wr_idx_q == IDX_LAST));

    // Write side; framing is purely counter based
    if (s_fire) begin
      wr_idx_d = wr_idx_q + 1'b1;
      if (wr_idx_q == IDX_LAST) begin
        state_d[wr_bank_q] = BANK_FULL;
        wr_bank_d          = ~wr_bank_q;
      end else begin
        state_d[wr_bank_q] = BANK_FILLING;
      end
    end

    // Read issue into the RAM output stage
    if (ren) begin
      state_d[iss_bank_q] = BANK_DRAINING;
      iss_idx_d           = iss_idx_q + 1'b1;
      bank_p1_d           = iss_bank_q;
      last_p1_d           = (iss_idx_q == IDX_LAST);
      if (iss_idx_q == IDX_LAST) iss_bank_d = ~iss_bank_q;
    end
    vld_p1_d = ren || (vld_p1_q && !adv_out);

    // Output register
    if (adv_out) begin
      m_valid_d = vld_p1_q;
      m_last_d  = vld_p1_q && last_p1_q;
      if (vld_p1_q) m_data_d = rdata[bank_p1_q];
    end

    // A bank is released only once its last sample is taken
    if (m_fire && m_last_q) begin
      state_d[rd_bank_q] = BANK_EMPTY;
      rd_bank_d          = ~rd_bank_q;
      cnt_d              = cnt_q + 1'b1;
    end
  end

  assign m_if.valid = m_valid_q;
  assign m_if.data  = m_data_q;
  assign m_if.last  = m_last_q;
  assign frame_err  = err_q;
  assign frame_cnt  = cnt_q;
endmodule

// File: tb/tb_dct_frame_buffer.sv
module tb_dct_frame_buffer;
  import dct_pkg::*;

  localparam int N = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_err;
  logic [15:0] frame_cnt;

  dct_frame_buffer_if #(.DW(32)) s_bus ();
  dct_frame_buffer_if #(.DW(32)) m_bus ();

  dct_frame_buffer #(.DW(32), .N(N), .CNTW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_if      (s_bus),
    .m_if      (m_bus),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rdy_pct = 100;

  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];
  int          exp_cyc_q[$];
  int          obs_cyc_q[$];
  int          err_cyc_q[$];
  int          cyc = 0;
  int          widx = 0;
  int          err_pulses = 0;
  int          hold_viol = 0;
  int          mv_rise_cyc = 0;
  int          last_fire_cyc = 0;
  logic        prev_mv = 1'b0;
  logic        prev_mr = 1'b0;
  logic [32:0] prev_out = '0;

  // Consumer ready generator
  always begin
    @(posedge clk);
    #1;
    m_bus.ready = (int'($urandom_range(0, 99)) < rdy_pct);
  end

  // Monitor: sampled on the falling edge, ahead of the transferring rising edge
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      widx    = 0;
      prev_mv = 1'b0;
    end else begin
      if (s_bus.valid && s_bus.ready) begin
        exp_q.push_back({(widx == N - 1), s_bus.data});
        exp_cyc_q.push_back(cyc);
        last_fire_cyc = cyc;
        widx = (widx + 1) % N;
      end
      if (m_bus.valid && m_bus.ready) begin
        obs_q.push_back({m_bus.last, m_bus.data});
        obs_cyc_q.push_back(cyc);
      end
      if (frame_err) begin
        err_pulses++;
        err_cyc_q.push_back(cyc);
      end
      if (m_bus.valid && !prev_mv) mv_rise_cyc = cyc;
      if (prev_mv && !prev_mr && (!m_bus.valid || ({m_bus.last, m_bus.data} !== prev_out)))
        hold_viol++;
      prev_mv  = m_bus.valid;
      prev_mr  = m_bus.ready;
      prev_out = {m_bus.last, m_bus.data};
    end
  end

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    s_bus.valid = 1'b0;
    s_bus.data  = '0;
    s_bus.last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    obs_q.delete();
    exp_cyc_q.delete();
    obs_cyc_q.delete();
    err_cyc_q.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drives n samples base+i; err_mode puts last on index 100 instead of N-1
  task automatic send(input int n, input int base, input int vpct, input bit err_mode,
                      output bit tmo);
    int i = 0;
    int guard = 0;
    tmo = 1'b0;
    while (i < n) begin
      s_bus.valid = (int'($urandom_range(0, 99)) < vpct);
      s_bus.data  = base + i;
      s_bus.last  = err_mode ? ((i % N) == 100) : ((i % N) == N - 1);
      @(negedge clk);
      if (s_bus.valid && s_bus.ready) i++;
      @(posedge clk);
      #1;
      guard++;
      if (guard > 20000) begin
        tmo = 1'b1;
        break;
      end
    end
    s_bus.valid = 1'b0;
    s_bus.last  = 1'b0;
  endtask

  task automatic wait_out(input int n, output bit tmo);
    int k = 0;
    tmo = 1'b0;
    while (obs_q.size() < n) begin
      @(posedge clk);
      #1;
      k++;
      if (k > 30000) begin
        tmo = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit tmo;
    logic [32:0] e, o;
    @(posedge clk);
    #1;
    checks++; if (m_bus.valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b want 0", m_bus.valid); end
    checks++; if (m_bus.last !== 1'b0) begin errors++; $display("FAIL rst_m_last: got %b want 0", m_bus.last); end
    checks++; if (m_bus.data !== 32'd0) begin errors++; $display("FAIL rst_m_data: got %h want 0", m_bus.data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (s_bus.ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready: got %b want 1", s_bus.ready); end
    rdy_pct = 0;
    send(100, 1000, 100, 1'b0, tmo);
    rst_n = 1'b0;
    #2;
    checks++; if (m_bus.valid !== 1'b0 || frame_cnt !== 16'd0) begin errors++; $display("FAIL midrst_async: got m_valid=%b cnt=%0d want 0/0", m_bus.valid, frame_cnt); end
    apply_reset();
    checks++; if (s_bus.ready !== 1'b1 || m_bus.valid !== 1'b0 || frame_cnt !== 16'd0) begin
      errors++; $display("FAIL midrst_release: got s_ready=%b m_valid=%b cnt=%0d want 1/0/0", s_bus.ready, m_bus.valid, frame_cnt);
    end
    rdy_pct = 100;
    send(256, 0, 100, 1'b0, tmo);
    wait_out(256, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL midrst_drain: got %0d outputs want 256", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL midrst_order: got last=%b data=%0d want last=%b data=%0d", o[32], o[31:0], e[32], e[31:0]); end
    end
    @(posedge clk);
    #1;
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL midrst_cnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_single();
    bit tmo;
    int e0;
    logic [32:0] e, o;
    apply_reset();
    rdy_pct = 100;
    e0 = err_pulses;
    send(256, 0, 100, 1'b0, tmo);
    wait_out(256, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL single_drain: got %0d outputs want 256", obs_q.size()); end
    checks++; if (mv_rise_cyc - last_fire_cyc !== 3) begin
      errors++; $display("FAIL single_latency: got m_valid rise %0d negedges after last input want 3", mv_rise_cyc - last_fire_cyc);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL single_order: got last=%b data=%0d want last=%b data=%0d", o[32], o[31:0], e[32], e[31:0]); end
    end
    @(posedge clk);
    #1;
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", frame_cnt); end
    checks++; if (err_pulses - e0 !== 0) begin errors++; $display("FAIL single_frame_err: got %0d pulses want 0", err_pulses - e0); end
  endtask

  task automatic test_back_to_back();
    bit tmo;
    logic [32:0] e, o;
    apply_reset();
    rdy_pct = 100;
    send(1024, 0, 100, 1'b0, tmo);
    wait_out(1024, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL b2b_drain: got %0d outputs want 1024", obs_q.size()); end
    if (obs_cyc_q.size() >= 1024) begin
      for (int f = 0; f < 4; f++) begin
        checks++; if (obs_cyc_q[f*256 + 255] - obs_cyc_q[f*256] !== 255) begin
          errors++; $display("FAIL b2b_gapless_frame%0d: got span %0d want 255", f, obs_cyc_q[f*256 + 255] - obs_cyc_q[f*256]);
        end
      end
      checks++; if (obs_cyc_q[256] - obs_cyc_q[255] !== 1) begin
        errors++; $display("FAIL b2b_frame_handover: got gap %0d want 1", obs_cyc_q[256] - obs_cyc_q[255]);
      end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL b2b_order: got last=%b data=%0d want last=%b data=%0d", o[32], o[31:0], e[32], e[31:0]); end
    end
    @(posedge clk);
    #1;
    checks++; if (frame_cnt !== 16'd4) begin errors++; $display("FAIL b2b_cnt: got %0d want 4", frame_cnt); end
  endtask

  task automatic test_backpressure();
    bit tmo_a, tmo_b;
    int h0;
    logic [32:0] e, o;
    apply_reset();
    rdy_pct = 0;
    h0 = hold_viol;
    fork
      send(768, 5000, 100, 1'b0, tmo_a);
      begin
        repeat (600) @(posedge clk);
        #1;
        checks++; if (exp_q.size() !== 512) begin errors++; $display("FAIL bp_accepted: got %0d samples want 512", exp_q.size()); end
        checks++; if (s_bus.ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready: got %b want 0", s_bus.ready); end
        checks++; if (m_bus.valid !== 1'b1 || m_bus.data !== 32'd5000 || m_bus.last !== 1'b0) begin
          errors++; $display("FAIL bp_frozen_out: got valid=%b data=%0d last=%b want 1/5000/0", m_bus.valid, m_bus.data, m_bus.last);
        end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL bp_cnt_frozen: got %0d want 0", frame_cnt); end
        rdy_pct = 100;
      end
    join
    checks++; if (tmo_a) begin errors++; $display("FAIL bp_input_timeout: got %0d samples want 768", exp_q.size()); end
    wait_out(768, tmo_b);
    checks++; if (tmo_b) begin errors++; $display("FAIL bp_drain: got %0d outputs want 768", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL bp_order: got last=%b data=%0d want last=%b data=%0d", o[32], o[31:0], e[32], e[31:0]); end
    end
    @(posedge clk);
    #1;
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL bp_cnt: got %0d want 3", frame_cnt); end
    checks++; if (hold_viol - h0 !== 0) begin errors++; $display("FAIL bp_hold: got %0d unstable stalled outputs want 0", hold_viol - h0); end
  endtask

  task automatic test_framing();
    bit tmo;
    int e0;
    logic [32:0] e, o;
    apply_reset();
    rdy_pct = 100;
    e0 = err_pulses;
    send(256, 200, 100, 1'b1, tmo);
    wait_out(256, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL frm_drain: got %0d outputs want 256", obs_q.size()); end
    checks++; if (err_pulses - e0 !== 2) begin errors++; $display("FAIL frm_pulses: got %0d want 2", err_pulses - e0); end
    if (err_cyc_q.size() >= 2 && exp_cyc_q.size() >= 256) begin
      checks++; if (err_cyc_q[0] !== exp_cyc_q[100] + 1) begin
        errors++; $display("FAIL frm_pulse_idx100: got cycle %0d want %0d", err_cyc_q[0], exp_cyc_q[100] + 1);
      end
      checks++; if (err_cyc_q[1] !== exp_cyc_q[255] + 1) begin
        errors++; $display("FAIL frm_pulse_idx255: got cycle %0d want %0d", err_cyc_q[1], exp_cyc_q[255] + 1);
      end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL frm_order: got last=%b data=%0d want last=%b data=%0d", o[32], o[31:0], e[32], e[31:0]); end
    end
    @(posedge clk);
    #1;
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL frm_cnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_random();
    bit tmo;
    int h0;
    logic [32:0] e, o;
    apply_reset();
    rdy_pct = 50;
    h0 = hold_viol;
    send(20 * N, 0, 50, 1'b0, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL rnd_input_timeout: got %0d samples want %0d", exp_q.size(), 20 * N); end
    wait_out(20 * N, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL rnd_drain: got %0d outputs want %0d", obs_q.size(), 20 * N); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL rnd_order: got last=%b data=%0d want last=%b data=%0d", o[32], o[31:0], e[32], e[31:0]); end
    end
    @(posedge clk);
    #1;
    checks++; if (frame_cnt !== 16'd20) begin errors++; $display("FAIL rnd_cnt: got %0d want 20", frame_cnt); end
    checks++; if (hold_viol - h0 !== 0) begin errors++; $display("FAIL rnd_hold: got %0d unstable stalled outputs want 0", hold_viol - h0); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    s_bus.valid = 1'b0;
    s_bus.data  = '0;
    s_bus.last  = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_framing();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
